dm_arbiter: RTL and testbench

DM_ARBITER -- requirements
Module: dm_arbiter

---
 rtl/dm_arbiter.sv | 124 ++++++++++++
 tb/tb_dm_arbiter.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_arbiter.sv
// Round-robin arbiter sharing one data-memory port between the CPU MEM stage
// and the program loader; each grant is a single-cycle access.
//
// state   | meaning
// IDLE    | no access; memory port parked at zero
// ACC_CPU | CPU owns the memory port for this cycle
// ACC_LD  | loader owns the memory port for this cycle
module dm_arbiter #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_stall,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rvalid,
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic              ld_gnt,
  output logic [DATA_W-1:0] ld_rdata,
  output logic              ld_rvalid,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [DATA_W-1:0] dm_wdata,
  output logic              dm_we,
  output logic              dm_re,
  input  logic [DATA_W-1:0] dm_rdata,
  output logic [15:0]       cpu_wait_cnt
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ACC_CPU = 2'd1;
  localparam logic [1:0] ACC_LD  = 2'd2;

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic       last_ld;
  logic       cpu_m;
  logic       ld_m;

  // A requester's held request is masked during its own access so it cannot
  // be serviced twice; staying high afterwards counts as a fresh request.
  always_comb begin
    cpu_m     = cpu_req && (state != ACC_CPU);
    ld_m      = ld_req && (state != ACC_LD);
    state_nxt = IDLE;
    if (cpu_m && ld_m) begin
      state_nxt = last_ld ? ACC_CPU : ACC_LD;
    end else if (cpu_m) begin
      state_nxt = ACC_CPU;
    end else if (ld_m) begin
      state_nxt = ACC_LD;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      last_ld <= 1'b1;
    end else begin
      state <= state_nxt;
      if (state_nxt == ACC_CPU) begin
        last_ld <= 1'b0;
      end else if (state_nxt == ACC_LD) begin
        last_ld <= 1'b1;
      end
    end
  end

  assign cpu_gnt   = (state == ACC_CPU);
  assign ld_gnt    = (state == ACC_LD);
  assign cpu_stall = cpu_req && !cpu_gnt;

  always_comb begin
    dm_addr  = '0;
    dm_wdata = '0;
    dm_we    = 1'b0;
    dm_re    = 1'b0;
    if (cpu_gnt) begin
      dm_addr  = cpu_addr;
      dm_wdata = cpu_wdata;
      dm_we    = cpu_we;
      dm_re    = !cpu_we;
    end else if (ld_gnt) begin
      dm_addr  = ld_addr;
      dm_wdata = ld_wdata;
      dm_we    = ld_we;
      dm_re    = !ld_we;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpu_rdata  <= '0;
      cpu_rvalid <= 1'b0;
      ld_rdata   <= '0;
      ld_rvalid  <= 1'b0;
    end else begin
      cpu_rvalid <= cpu_gnt && !cpu_we;
      ld_rvalid  <= ld_gnt && !ld_we;
      if (cpu_gnt && !cpu_we) begin
        cpu_rdata <= dm_rdata;
      end
      if (ld_gnt && !ld_we) begin
        ld_rdata <= dm_rdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpu_wait_cnt <= '0;
    end else if (cpu_stall && (cpu_wait_cnt != 16'hFFFF)) begin
      cpu_wait_cnt <= cpu_wait_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_dm_arbiter.sv
// Bench for dm_arbiter: directed vector table, hand-written corner sequences,
// and random traffic checked against a transaction-level reference model.
module tb_dm_arbiter;
  localparam int AW = 7;
  localparam int DW = 32;
  localparam int VW = 126;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cpu_req, cpu_we, cpu_gnt, cpu_stall, cpu_rvalid;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic          ld_req, ld_we, ld_gnt, ld_rvalid;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_wdata, ld_rdata;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata, dm_rdata;
  logic          dm_we, dm_re;
  logic [15:0]   cpu_wait_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  dm_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
    .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .ld_gnt(ld_gnt), .ld_rdata(ld_rdata), .ld_rvalid(ld_rvalid),
    .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_we(dm_we), .dm_re(dm_re),
    .dm_rdata(dm_rdata), .cpu_wait_cnt(cpu_wait_cnt)
  );

  always #5 clk = ~clk;

  // data memory attached to the arbiter
  logic [DW-1:0] mem [0:127] = '{default: '0};
  always @(posedge clk) if (dm_we) mem[dm_addr] <= dm_wdata;
  assign dm_rdata = mem[dm_addr];

  logic [VW-1:0] act;
  assign act = {cpu_gnt, ld_gnt, cpu_stall, dm_we, dm_re, dm_addr, dm_wdata,
                cpu_rvalid, cpu_rdata, ld_rvalid, ld_rdata, cpu_wait_cnt};

  typedef struct {
    logic          rst;
    logic          creq, cwe;
    logic [AW-1:0] caddr;
    logic [DW-1:0] cwd;
    logic          lreq, lwe;
    logic [AW-1:0] laddr;
    logic [DW-1:0] lwd;
    logic [VW-1:0] exp;
  } vec_t;

  function automatic vec_t mk(
    input logic rst, creq, cwe, input logic [AW-1:0] caddr, input logic [DW-1:0] cwd,
    input logic lreq, lwe, input logic [AW-1:0] laddr, input logic [DW-1:0] lwd,
    input logic cg, lg, st, we, re, input logic [AW-1:0] a, input logic [DW-1:0] wd,
    input logic crv, input logic [DW-1:0] crd, input logic lrv, input logic [DW-1:0] lrd,
    input logic [15:0] cnt);
    vec_t v;
    v.rst = rst; v.creq = creq; v.cwe = cwe; v.caddr = caddr; v.cwd = cwd;
    v.lreq = lreq; v.lwe = lwe; v.laddr = laddr; v.lwd = lwd;
    v.exp = {cg, lg, st, we, re, a, wd, crv, crd, lrv, lrd, cnt};
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [VW-1:0] a, input logic [VW-1:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s[%0d] got %h want %h", name, idx, a, e);
    end
  endtask

  task automatic chk1(input string name, input int idx, input logic [31:0] a, input logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s[%0d] got %h want %h", name, idx, a, e);
    end
  endtask

  task automatic set_in(input logic creq, cwe, input logic [AW-1:0] caddr, input logic [DW-1:0] cwd,
                        input logic lreq, lwe, input logic [AW-1:0] laddr, input logic [DW-1:0] lwd);
    cpu_req = creq; cpu_we = cwe; cpu_addr = caddr; cpu_wdata = cwd;
    ld_req = lreq; ld_we = lwe; ld_addr = laddr; ld_wdata = lwd;
  endtask

  // called just after a rising edge; releases before the next one
  task automatic pulse_rst();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  // reference model: who owns the port this cycle, who was served last (1=CPU, 2=LD)
  int            m_owner, m_last, m_prev;
  logic [DW-1:0] m_crd, m_lrd;
  logic          m_crv, m_lrv;
  int            m_cnt;
  logic [DW-1:0] m_mem [0:127];
  int            m_cyc;

  task automatic model_reset();
    m_owner = 0; m_last = 2; m_prev = 0;
    m_crd = '0; m_lrd = '0; m_crv = 1'b0; m_lrv = 1'b0; m_cnt = 0;
    for (int i = 0; i < 128; i++) m_mem[i] = mem[i];
  endtask

  task automatic model_step(input logic check);
    logic          e_st, e_we, e_re, cm, lm;
    logic [AW-1:0] e_a;
    logic [DW-1:0] e_wd;
    e_st = cpu_req && (m_owner != 1);
    e_we = 1'b0; e_re = 1'b0; e_a = '0; e_wd = '0;
    if (m_owner == 1) begin
      e_we = cpu_we; e_re = !cpu_we; e_a = cpu_addr; e_wd = cpu_wdata;
    end else if (m_owner == 2) begin
      e_we = ld_we; e_re = !ld_we; e_a = ld_addr; e_wd = ld_wdata;
    end
    if (check)
      chk("rand", m_cyc, act, {m_owner == 1, m_owner == 2, e_st, e_we, e_re, e_a, e_wd,
                               m_crv, m_crd, m_lrv, m_lrd, 16'(m_cnt)});
    m_cyc++;
    m_crv = 1'b0;
    m_lrv = 1'b0;
    if (m_owner == 1) begin
      if (cpu_we) m_mem[cpu_addr] = cpu_wdata;
      else begin m_crd = m_mem[cpu_addr]; m_crv = 1'b1; end
    end else if (m_owner == 2) begin
      if (ld_we) m_mem[ld_addr] = ld_wdata;
      else begin m_lrd = m_mem[ld_addr]; m_lrv = 1'b1; end
    end
    if (e_st && m_cnt < 65535) m_cnt++;
    cm = cpu_req && (m_owner != 1);
    lm = ld_req && (m_owner != 2);
    m_prev = m_owner;
    if (cm && lm) m_owner = (m_last == 2) ? 1 : 2;
    else if (cm) m_owner = 1;
    else if (lm) m_owner = 2;
    else m_owner = 0;
    if (m_owner != 0) m_last = m_owner;
  endtask

  function automatic logic [AW-1:0] rnd_addr();
    logic [AW-1:0] a;
    a = ($urandom_range(0, 3) == 0) ? 7'd127 : 7'($urandom_range(0, 7));
    return a;
  endfunction

  vec_t tbl [16];
  logic c_pend, l_pend;
  logic [DW-1:0] h, c, aa;

  initial begin
    h = 32'h1234_5678; c = 32'hCAFE_BABE; aa = 32'h0000_00AA;
    tbl[0]  = mk(1, 1,1,5,h, 0,0,0,0,     0,0,1,0,0,0,0,   0,0,0,0,0);
    tbl[1]  = mk(0, 1,1,5,h, 0,0,0,0,     1,0,0,1,0,5,h,   0,0,0,0,1);
    tbl[2]  = mk(0, 1,0,5,0, 0,0,0,0,     0,0,1,0,0,0,0,   0,0,0,0,1);
    tbl[3]  = mk(0, 1,0,5,0, 0,0,0,0,     1,0,0,0,1,5,0,   0,0,0,0,2);
    tbl[4]  = mk(0, 0,0,0,0, 0,0,0,0,     0,0,0,0,0,0,0,   1,h,0,0,2);
    tbl[5]  = mk(0, 0,0,0,0, 0,0,0,0,     0,0,0,0,0,0,0,   0,h,0,0,2);
    tbl[6]  = mk(1, 1,0,3,0, 1,1,9,aa,    0,0,1,0,0,0,0,   0,0,0,0,0);
    tbl[7]  = mk(0, 1,0,3,0, 1,1,9,aa,    1,0,0,0,1,3,0,   0,0,0,0,1);
    tbl[8]  = mk(0, 0,0,0,0, 1,1,9,aa,    0,1,0,1,0,9,aa,  1,0,0,0,1);
    tbl[9]  = mk(0, 0,0,0,0, 0,0,0,0,     0,0,0,0,0,0,0,   0,0,0,0,1);
    tbl[10] = mk(0, 0,0,0,0, 1,1,127,c,   0,0,0,0,0,0,0,   0,0,0,0,1);
    tbl[11] = mk(0, 0,0,0,0, 1,1,127,c,   0,1,0,1,0,127,c, 0,0,0,0,1);
    tbl[12] = mk(0, 0,0,0,0, 1,0,127,0,   0,0,0,0,0,0,0,   0,0,0,0,1);
    tbl[13] = mk(0, 0,0,0,0, 1,0,127,0,   0,1,0,0,1,127,0, 0,0,0,0,1);
    tbl[14] = mk(0, 0,0,0,0, 0,0,0,0,     0,0,0,0,0,0,0,   0,0,1,c,1);
    tbl[15] = mk(0, 0,0,0,0, 0,0,0,0,     0,0,0,0,0,0,0,   0,0,0,c,1);

    set_in(0,0,0,0, 0,0,0,0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("reset", 0, act, '0);
    set_in(1,1,7'd5,32'hFFFF_FFFF, 1,0,7'd127,32'hFFFF_FFFF);
    #1;
    chk("reset_req", 0, {act[VW-1:VW-2], act[VW-4:0]}, '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    set_in(0,0,0,0, 0,0,0,0);
    @(posedge clk); #1;

    for (int i = 0; i < 16; i++) begin
      if (tbl[i].rst) pulse_rst();
      set_in(tbl[i].creq, tbl[i].cwe, tbl[i].caddr, tbl[i].cwd,
             tbl[i].lreq, tbl[i].lwe, tbl[i].laddr, tbl[i].lwd);
      @(negedge clk);
      chk("tbl", i, act, tbl[i].exp);
      @(posedge clk); #1;
    end

    // continuous contention alternates grants starting with the CPU
    pulse_rst();
    set_in(1,0,7'd1,0, 1,0,7'd2,0);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      chk1("rr_cpu_gnt", i, 32'(cpu_gnt), 32'(i % 2 == 1));
      chk1("rr_ld_gnt", i, 32'(ld_gnt), 32'(i > 0 && i % 2 == 0));
      @(posedge clk); #1;
    end

    // reset during a loader read aborts it immediately
    set_in(0,0,0,0, 0,0,0,0);
    pulse_rst();
    set_in(0,0,0,0, 1,0,7'd4,0);
    @(posedge clk); #1;
    @(negedge clk);
    chk1("abort_pre_gnt", 0, 32'(ld_gnt), 1);
    chk1("abort_pre_re", 0, 32'(dm_re), 1);
    #1;
    rst_n = 1'b0;
    ld_req = 1'b0;
    #1;
    chk1("abort_gnt", 0, 32'(ld_gnt), 0);
    chk1("abort_re", 0, 32'(dm_re), 0);
    chk1("abort_rvalid", 0, 32'(ld_rvalid), 0);
    @(posedge clk); #1;
    chk1("abort_rvalid", 1, 32'(ld_rvalid), 0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk1("post_abort", i, 32'({cpu_gnt, ld_gnt, ld_rvalid, cpu_rvalid, dm_re}), 0);
      @(posedge clk); #1;
    end

    // random traffic against the reference model
    pulse_rst();
    model_reset();
    m_cyc = 0;
    c_pend = 1'b0; l_pend = 1'b0;
    set_in(0,0,0,0, 0,0,0,0);
    for (int i = 0; i < 3000; i++) begin
      if (m_prev == 1) c_pend = 1'b0;
      if (m_prev == 2) l_pend = 1'b0;
      if (!c_pend) begin
        c_pend = ($urandom_range(0, 9) < 6);
        cpu_req = c_pend; cpu_we = 1'($urandom); cpu_addr = rnd_addr(); cpu_wdata = $urandom;
      end
      if (!l_pend) begin
        l_pend = ($urandom_range(0, 9) < 6);
        ld_req = l_pend; ld_we = 1'($urandom); ld_addr = rnd_addr(); ld_wdata = $urandom;
      end
      @(negedge clk);
      model_step(1);
      @(posedge clk); #1;
    end

    // saturating stall counter: run a contention stream up to 16'hFFFE
    set_in(0,0,0,0, 0,0,0,0);
    pulse_rst();
    model_reset();
    set_in(1,0,7'd10,0, 1,0,7'd11,0);
    for (int i = 0; i < 140000 && m_cnt != 65534; i++) begin
      @(negedge clk);
      model_step(0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk1("sat_preload", 0, 32'(cpu_wait_cnt), 32'h0000_FFFE);
    model_step(1);
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      model_step(1);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk1("sat_hold", 0, 32'(cpu_wait_cnt), 32'h0000_FFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
